soundrive_dac: RTL and testbench

Four-channel 8-bit DAC port block, the successor to the single-latch Specdrum port. It decodes Z80 I/O writes to four Soundrive/Covox channel ports, plus optionally the legacy mono Specdrum ports. It accepts exactly one write per I/O cycle and mixes the channels into a registered stereo pair (A+B left, C+D right). It sits between the CPU bus and the audio mixer, in parallel with the other sound peripherals.

---
 rtl/soundrive_dac_if.sv | 37 +++
 rtl/soundrive_dac.sv | 128 ++++++++++++
 tb/tb_soundrive_dac.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soundrive_dac_if.sv
// ---------------------------------------------------------------------------
// soundrive_dac_if
//   Bundles the Z80 I/O write bus and the DAC outputs for soundrive_dac.
//   master : CPU/bus side, drives address, strobes, data and enable.
//   slave  : DAC side, drives wr_ack, channel registers and the stereo mix.
// Signals:
//   a[15:0]        CPU address bus (only a[7:0] decoded)
//   iorq_n         I/O request, active low
//   wr_n           write strobe, active low
//   d[7:0]         CPU data bus
//   enable         1 = block responds to writes
//   wr_ack         one-cycle pulse when a write is accepted
//   dac_chan[31:0] channel registers {D,C,B,A}, raw unsigned
//   left_out[8:0]  registered mix of A+B
//   right_out[8:0] registered mix of C+D
// ---------------------------------------------------------------------------
interface soundrive_dac_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        wr_n;
  logic [7:0]  d;
  logic        enable;
  logic        wr_ack;
  logic [31:0] dac_chan;
  logic [8:0]  left_out;
  logic [8:0]  right_out;

  modport master (
    output a, iorq_n, wr_n, d, enable,
    input  wr_ack, dac_chan, left_out, right_out
  );

  modport slave (
    input  a, iorq_n, wr_n, d, enable,
    output wr_ack, dac_chan, left_out, right_out
  );
endinterface

// File: rtl/soundrive_dac.sv
// ---------------------------------------------------------------------------
// soundrive_dac
//   Four-channel 8-bit Soundrive/Covox DAC port block. Decodes Z80 I/O writes
//   to the four channel ports (and optionally the legacy mono Specdrum ports),
//   accepts exactly one write per I/O strobe assertion, and produces a
//   registered stereo mix: left = A+B, right = C+D.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    soundrive_dac_if.slave (a, iorq_n, wr_n, d, enable in;
//          wr_ack, dac_chan, left_out, right_out out)
//
// Parameters:
//   PORT_A..PORT_D  low address byte of each channel port
//   PORT_M0/PORT_M1 legacy mono ports (write all four channels)
//   SIGNED_OUT      0 = unsigned mix (0..510), 1 = two's-complement (-256..254)
//
// Configuration macro:
//   SOUNDRIVE_MONO_PORTS_EN  when defined, PORT_M0/PORT_M1 are decoded and
//                            load d into all four channels. When undefined
//                            those addresses are ignored entirely.
// ---------------------------------------------------------------------------
module soundrive_dac #(
  parameter logic [7:0] PORT_A     = 8'h0F,
  parameter logic [7:0] PORT_B     = 8'h1F,
  parameter logic [7:0] PORT_C     = 8'h4F,
  parameter logic [7:0] PORT_D     = 8'h5F,
  parameter logic [7:0] PORT_M0    = 8'hDF,
  parameter logic [7:0] PORT_M1    = 8'hFB,
  parameter bit         SIGNED_OUT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  soundrive_dac_if.slave  bus
);

  // Mix output value when every channel sits at midscale (8'h80).
  localparam logic [8:0] MIX_RESET = SIGNED_OUT ? 9'h000 : 9'h100;

  // Per-channel contribution to the mix: zero-extended when unsigned, or
  // offset-binary to two's complement (invert MSB) and sign-extended.
  function automatic logic [8:0] to_mix(input logic [7:0] x);
    if (SIGNED_OUT) return {~x[7], ~x[7], x[6:0]};
    else            return {1'b0, x};
  endfunction

  logic [3:0][7:0] r_chan;
  logic            r_wstb_q;
  logic            r_wr_ack;
  logic [8:0]      r_left;
  logic [8:0]      r_right;

  logic            w_wstb;
  logic [3:0]      w_sel;
  logic            w_accept;
  logic            w_unused_hi;

  assign w_wstb = !bus.iorq_n && !bus.wr_n;

  // Only the low address byte takes part in decoding.
  assign w_unused_hi = ^bus.a[15:8];

  // One-hot (or all-ones for mono) channel select from the low address byte.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_sel = 4'b0000;
    unique case (bus.a[7:0])
      PORT_A:  w_sel = 4'b0001;
      PORT_B:  w_sel = 4'b0010;
      PORT_C:  w_sel = 4'b0100;
      PORT_D:  w_sel = 4'b1000;
`ifdef SOUNDRIVE_MONO_PORTS_EN
      PORT_M0: w_sel = 4'b1111;
      PORT_M1: w_sel = 4'b1111;
`endif
      default: w_sel = 4'b0000;
    endcase
  end

  // Accept only on the rising edge of the strobe: a held strobe writes once,
  // and raising enable mid-strobe does not create a late write.
  assign w_accept = w_wstb && !r_wstb_q && bus.enable && (w_sel != 4'b0000);

  // Strobe history is tracked unconditionally so edge detection is never
  // fooled by enable or address changes during a held strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_wstb_q <= 1'b0;
      r_wr_ack <= 1'b0;
    end else begin
      r_wstb_q <= w_wstb;
      r_wr_ack <= w_accept;
    end
  end

  // Channel registers. They drive audio directly, so they are reset to a
  // known midscale value rather than left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan <= {4{8'h80}};
    end else if (w_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (w_sel[i]) r_chan[i] <= bus.d;
      end
    end
  end

  // Mix stage: one clock behind the channel registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left  <= MIX_RESET;
      r_right <= MIX_RESET;
    end else begin
      r_left  <= to_mix(r_chan[0]) + to_mix(r_chan[1]);
      r_right <= to_mix(r_chan[2]) + to_mix(r_chan[3]);
    end
  end

  assign bus.wr_ack    = r_wr_ack;
  assign bus.dac_chan  = r_chan;
  assign bus.left_out  = r_left;
  assign bus.right_out = r_right;

endmodule

// File: tb/tb_soundrive_dac.sv
// ---------------------------------------------------------------------------
// tb_soundrive_dac
//   Self-checking bench for soundrive_dac. Two instances share the same bus
//   stimulus: one unsigned (SIGNED_OUT=0), one signed (SIGNED_OUT=1).
//   Honours SOUNDRIVE_MONO_PORTS_EN when computing expectations.
// ---------------------------------------------------------------------------
module tb_soundrive_dac;

`ifdef SOUNDRIVE_MONO_PORTS_EN
  localparam bit MONO = 1'b1;
`else
  localparam bit MONO = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic        iorq_n;
  logic        wr_n;
  logic [7:0]  d;
  logic        enable;

  int total = 0;
  int bad   = 0;

  soundrive_dac_if u_if_u ();
  soundrive_dac_if u_if_s ();

  assign u_if_u.a = a;      assign u_if_s.a = a;
  assign u_if_u.iorq_n = iorq_n; assign u_if_s.iorq_n = iorq_n;
  assign u_if_u.wr_n = wr_n;  assign u_if_s.wr_n = wr_n;
  assign u_if_u.d = d;      assign u_if_s.d = d;
  assign u_if_u.enable = enable; assign u_if_s.enable = enable;

  soundrive_dac #(.SIGNED_OUT(1'b0)) u_dut_u (.clk(clk), .rst_n(rst_n), .bus(u_if_u));
  soundrive_dac #(.SIGNED_OUT(1'b1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(u_if_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0] m_ch [4];

  function automatic logic [8:0] ref_mix(input logic [7:0] x, input logic [7:0] y,
                                         input bit sgn);
    int s;
    if (sgn) s = (int'(x) - 128) + (int'(y) - 128);
    else     s = int'(x) + int'(y);
    return 9'(s);
  endfunction

  function automatic logic [31:0] model_chan();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
  endfunction

  // Applies one I/O write to the model; returns 1 if it is accepted.
  function automatic bit model_write(input logic [15:0] addr, input logic [7:0] data,
                                     input logic en);
    int idx;
    idx = -1;
    case (addr[7:0])
      8'h0F: idx = 0;
      8'h1F: idx = 1;
      8'h4F: idx = 2;
      8'h5F: idx = 3;
      8'hDF, 8'hFB: idx = MONO ? 4 : -1;
      default: idx = -1;
    endcase
    if (!en || idx < 0) return 1'b0;
    if (idx == 4) for (int k = 0; k < 4; k++) m_ch[k] = data;
    else m_ch[idx] = data;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) m_ch[k] = 8'h80;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " chan_u"}, u_if_u.dac_chan, model_chan());
    check({tag, " chan_s"}, u_if_s.dac_chan, model_chan());
    check({tag, " left_u"}, 32'(u_if_u.left_out), 32'(ref_mix(m_ch[0], m_ch[1], 1'b0)));
    check({tag, " right_u"}, 32'(u_if_u.right_out), 32'(ref_mix(m_ch[2], m_ch[3], 1'b0)));
    check({tag, " left_s"}, 32'(u_if_s.left_out), 32'(ref_mix(m_ch[0], m_ch[1], 1'b1)));
    check({tag, " right_s"}, 32'(u_if_s.right_out), 32'(ref_mix(m_ch[2], m_ch[3], 1'b1)));
  endtask

  // One I/O write cycle: strobe held for 'hold' clocks, d forced to 0xFF
  // after the first cycle, then released and left to settle through the mix.
  task automatic io_write(input logic [15:0] addr, input logic [7:0] data,
                          input int hold, input logic en, output int acks);
    @(negedge clk);
    a = addr; d = data; enable = en; iorq_n = 1'b0; wr_n = 1'b0;
    acks = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (u_if_u.wr_ack) acks++;
      if (u_if_s.wr_ack !== u_if_u.wr_ack) acks += 100;
      d = 8'hFF;
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    if (u_if_u.wr_ack) acks++;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        en;
    logic        exp_ack;
    logic [31:0] exp_chan;
  } vec_t;

  vec_t vt [9];

  initial begin
    int acks;
    bit acc;
    logic [15:0] ra;
    logic [7:0]  rd;
    logic        ren;
    int          rh;
    logic [7:0]  port_list [6];

    port_list[0] = 8'h0F; port_list[1] = 8'h1F; port_list[2] = 8'h4F;
    port_list[3] = 8'h5F; port_list[4] = 8'hDF; port_list[5] = 8'hFB;

    // Sequence continues from the state after the single-write test (B=0x40).
    vt[0] = '{16'h001F, 8'h40, 1'b1, 1'b1, 32'h80804080};
    vt[1] = '{16'hFF0E, 8'h11, 1'b1, 1'b0, 32'h80804080};
    vt[2] = '{16'hFF2F, 8'h22, 1'b1, 1'b0, 32'h80804080};
    vt[3] = '{16'hFF0F, 8'h33, 1'b1, 1'b1, 32'h80804033};
    vt[4] = '{16'h004F, 8'h55, 1'b0, 1'b0, 32'h80804033};
    vt[5] = '{16'h004F, 8'h55, 1'b1, 1'b1, 32'h80554033};
    vt[6] = '{16'hAB5F, 8'h01, 1'b1, 1'b1, 32'h01554033};
    vt[7] = '{16'h00DF, 8'h10, 1'b1, MONO, MONO ? 32'h10101010 : 32'h01554033};
    vt[8] = '{16'h12FB, 8'h90, 1'b1, MONO,
              MONO ? 32'h90909090 : 32'h01554033};

    a = 16'h0000; d = 8'h00; iorq_n = 1'b1; wr_n = 1'b1; enable = 1'b1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- reset state ----
    check("reset wr_ack", 32'(u_if_u.wr_ack), 32'd0);
    check("reset chan", u_if_u.dac_chan, 32'h80808080);
    check("reset left_u", 32'(u_if_u.left_out), 32'h100);
    check("reset left_s", 32'(u_if_s.left_out), 32'h000);
    check_state("reset");

    // ---- single write with held strobe, d changed after first cycle ----
    @(negedge clk);
    a = 16'h001F; d = 8'h40; enable = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    check("single ack N+1", 32'(u_if_u.wr_ack), 32'd1);
    check("single chan N+1", u_if_u.dac_chan, 32'h80804080);
    check("single left N+1 old", 32'(u_if_u.left_out), 32'h100);
    d = 8'hFF;
    @(negedge clk);
    check("single ack N+2", 32'(u_if_u.wr_ack), 32'd0);
    check("single left N+2", 32'(u_if_u.left_out), 32'h0C0);
    repeat (2) @(negedge clk);
    check("single hold ack", 32'(u_if_u.wr_ack), 32'd0);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    acc = model_write(16'h001F, 8'h40, 1'b1);
    check_state("single");

    // ---- table-driven vectors ----
    foreach (vt[i]) begin
      io_write(vt[i].addr, vt[i].data, 1 + (i % 3), vt[i].en, acks);
      acc = model_write(vt[i].addr, vt[i].data, vt[i].en);
      check($sformatf("vec%0d ack", i), 32'(acks), 32'(vt[i].exp_ack));
      check($sformatf("vec%0d chan", i), u_if_u.dac_chan, vt[i].exp_chan);
      check_state($sformatf("vec%0d", i));
    end

    // ---- enable raised mid-strobe: no write ----
    @(negedge clk);
    a = 16'h000F; d = 8'h99; enable = 1'b0; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    acks = int'(u_if_u.wr_ack);
    enable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      acks += int'(u_if_u.wr_ack);
    end
    iorq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    check("enable mid-strobe ack", 32'(acks), 32'd0);
    check_state("enable mid-strobe");
    io_write(16'h000F, 8'h99, 2, 1'b1, acks);
    acc = model_write(16'h000F, 8'h99, 1'b1);
    check("enable next ack", 32'(acks), 32'd1);
    check_state("enable next");

    // ---- signed/unsigned extremes ----
    io_write(16'h000F, 8'hFF, 1, 1'b1, acks); acc = model_write(16'h000F, 8'hFF, 1'b1);
    io_write(16'h001F, 8'hFF, 1, 1'b1, acks); acc = model_write(16'h001F, 8'hFF, 1'b1);
    io_write(16'h004F, 8'h00, 1, 1'b1, acks); acc = model_write(16'h004F, 8'h00, 1'b1);
    io_write(16'h005F, 8'h00, 1, 1'b1, acks); acc = model_write(16'h005F, 8'h00, 1'b1);
    check("signed left max", 32'(u_if_s.left_out), 32'h0FE);
    check("signed right min", 32'(u_if_s.right_out), 32'h100);
    check("unsigned left max", 32'(u_if_u.left_out), 32'h1FE);
    check("unsigned right min", 32'(u_if_u.right_out), 32'h000);

    // ---- randomized writes vs model ----
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) ra = 16'($urandom);
      else ra = {8'($urandom), port_list[$urandom_range(0, 5)]};
      rd  = 8'($urandom);
      ren = ($urandom_range(0, 4) != 0);
      rh  = $urandom_range(1, 4);
      io_write(ra, rd, rh, ren, acks);
      acc = model_write(ra, rd, ren);
      check($sformatf("rand%0d ack a=%h", n, ra), 32'(acks), 32'(acc));
      check_state($sformatf("rand%0d", n));
    end

    // ---- asynchronous reset during a held strobe ----
    @(negedge clk);
    a = 16'h000F; d = 8'h77; enable = 1'b1; iorq_n = 1'b0; wr_n = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async rst chan", u_if_u.dac_chan, 32'h80808080);
    check("async rst left_u", 32'(u_if_u.left_out), 32'h100);
    check("async rst right_u", 32'(u_if_u.right_out), 32'h100);
    check("async rst left_s", 32'(u_if_s.left_out), 32'h000);
    check("async rst ack", 32'(u_if_u.wr_ack), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst held ack", 32'(u_if_u.wr_ack), 32'd1);
    acc = model_write(16'h000F, 8'h77, 1'b1);
    check("post-rst held chan", u_if_u.dac_chan, 32'h80808077);
    @(negedge clk);
    check("post-rst single ack", 32'(u_if_u.wr_ack), 32'd0);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    check_state("post-rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
